// File: rtl/hazard_pkg.sv
// Shared widths and latency-select encoding for the register hazard scoreboard.
// Builds with HAZARD_BYPASS_EN add forwarding flags to the top level.
package hazard_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int CNT_W    = 3;

   typedef enum logic [1:0] {
      LAT_ALU,
      LAT_LOAD,
      LAT_MUL
   } lat_sel_e;

endpackage

// File: rtl/sb_entry.sv
// One register's busy tracking: pending flag, remaining-latency count, load tag.
// A set beats a same-cycle clear; loads freeze their count while memory waits.
module sb_entry
   import hazard_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             set,
   input  logic [CNT_W-1:0] set_cnt,
   input  logic             set_load,
   input  logic             wb_hit,
   input  logic             mem_wait,
   output logic             pending,
   output logic [CNT_W-1:0] cnt,
   output logic             is_load
);

   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (!(is_load && mem_wait) && cnt != '0)
         cnt_nxt = cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
         cnt     <= '0;
         is_load <= 1'b0;
      end else if (set) begin
         pending <= 1'b1;
         cnt     <= set_cnt;
         is_load <= set_load;
      end else if (pending && (wb_hit || cnt_nxt == '0)) begin
         pending <= 1'b0;
         cnt     <= '0;
         is_load <= 1'b0;
      end else if (pending) begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard with branch flush generation.
// Define HAZARD_BYPASS_EN to allow near-complete ALU results to forward.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int ALU_LAT  = 1,
   parameter int LOAD_LAT = 3,
   parameter int MUL_LAT  = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   addr_a,
   input  logic [ADDR_W-1:0]   addr_b,
   input  logic                use_b,
   input  logic [ADDR_W-1:0]   addr_d,
   input  logic                write_out,
   input  logic                load_instr,
   input  logic                mul_instr,
   input  logic                branch_instr,
   input  logic                mem_wait,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_addr,
   output logic                stall,
   output logic                flush,
   output logic [NUM_REGS-1:0] pending_mask
`ifdef HAZARD_BYPASS_EN
   ,
   output logic                fwd_a,
   output logic                fwd_b
`endif
);

   logic [NUM_REGS-1:0]            pend;
   logic [NUM_REGS-1:0]            isld;
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q;
   logic                           flush_q;
   logic                           accept;
   logic                           haz_a;
   logic                           haz_b;
   lat_sel_e                       lat_sel;
   logic [CNT_W-1:0]               set_cnt;

   always_comb begin
      lat_sel = LAT_ALU;
      if (mul_instr)
         lat_sel = LAT_MUL;
      else if (load_instr)
         lat_sel = LAT_LOAD;
   end

   always_comb begin
      set_cnt = CNT_W'(ALU_LAT);
      unique case (lat_sel)
         LAT_MUL:  set_cnt = CNT_W'(MUL_LAT);
         LAT_LOAD: set_cnt = CNT_W'(LOAD_LAT);
         default:  set_cnt = CNT_W'(ALU_LAT);
      endcase
   end

`ifdef HAZARD_BYPASS_EN
   logic byp_a;
   logic byp_b;

   // A non-load result one cycle from done can be picked off the bypass path.
   assign byp_a = (cnt_q[addr_a] <= CNT_W'(1)) & ~isld[addr_a];
   assign byp_b = (cnt_q[addr_b] <= CNT_W'(1)) & ~isld[addr_b];
   assign haz_a = pend[addr_a] & ~byp_a;
   assign haz_b = pend[addr_b] & ~byp_b;
   assign fwd_a = issue_valid & pend[addr_a] & byp_a;
   assign fwd_b = issue_valid & use_b & pend[addr_b] & byp_b;
`else
   logic unused_ok;

   assign unused_ok = ^{cnt_q, isld};
   assign haz_a     = pend[addr_a];
   assign haz_b     = pend[addr_b];
`endif

   assign stall = issue_valid &
                  (haz_a | (use_b & haz_b) |
                   (write_out & pend[addr_d]) | flush_q);

   assign accept = issue_valid & ~stall;

   assign pend[0]  = 1'b0;
   assign isld[0]  = 1'b0;
   assign cnt_q[0] = '0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
      sb_entry u_ent (
         .clk      (clk),
         .reset    (reset),
         .set      (accept & write_out & (addr_d == ADDR_W'(r))),
         .set_cnt  (set_cnt),
         .set_load (load_instr),
         .wb_hit   (wb_valid & (wb_addr == ADDR_W'(r))),
         .mem_wait (mem_wait),
         .pending  (pend[r]),
         .cnt      (cnt_q[r]),
         .is_load  (isld[r])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flush_q <= 1'b0;
      else
         flush_q <= accept & branch_instr;
   end

   assign flush        = flush_q;
   assign pending_mask = pend;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ALU_LAT, 1, cycles from issue to result for ALU ops; LOAD_LAT, 3, cycles for loads absent memory wait; MUL_LAT, 5, cycles for mul ops.
REQ-002 One clock; reset is asynchronous and active-high; ports SHALL be named clk and reset.
REQ-003 Ports SHALL be (name, direction, width, meaning), in this order:
- clk, in, 1, clock.
- reset, in, 1, async active-high reset.
- issue_valid, in, 1, decode holds a valid instruction.
- addr_a, in, 5, src1 register.
- addr_b, in, 5, src2 register.
- use_b, in, 1, src2 is read (low when the immediate is selected).
- addr_d, in, 5, destination register.
- write_out, in, 1, instruction writes a register.
- load_instr, in, 1, load.
- mul_instr, in, 1, mul.
- branch_instr, in, 1, branch.
- mem_wait, in, 1, cache/memory not ready.
- wb_valid, in, 1, writeback this cycle.
- wb_addr, in, 5, writeback register.
- stall, out, 1, hold fetch/decode.
- flush, out, 1, kill the instruction in fetch.
- pending_mask, out, 32, registered per-register busy bits.

Function
REQ-004 Per register r in 1..31 the block SHALL hold pending[r], cnt[r] (3 bits) and is_load[r]; register 0 SHALL never be pending.
REQ-005 stall SHALL be combinational: issue_valid & (pending[addr_a] | (use_b & pending[addr_b]) | (write_out & pending[addr_d])).
REQ-006 An instruction SHALL be accepted when issue_valid & ~stall.
REQ-007 On acceptance with write_out and addr_d≠0, the next edge SHALL set pending[addr_d]=1, cnt to MUL_LAT if mul_instr, else LOAD_LAT if load_instr, else ALU_LAT, and is_load=load_instr.
REQ-008 Each cycle every pending entry with cnt>0 SHALL decrement by 1, except that load entries SHALL hold their count while mem_wait=1.
REQ-009 When cnt=0, or on wb_valid with wb_addr=r, pending[r] SHALL clear at the next edge.
REQ-010 If a set (REQ-007) and a clear (REQ-009) target the same register in the same cycle, the set SHALL win.
REQ-011 flush SHALL be registered and high for exactly one cycle after an accepted branch_instr.
REQ-012 A branch arriving while flush=1 SHALL NOT be accepted; stall SHALL also include flush.
REQ-013 pending_mask[r] SHALL equal pending[r]; bit 0 SHALL be 0.
REQ-014 Simultaneous mem_wait and wb_valid to a load entry SHALL clear that entry.

Reset
REQ-015 While reset=1: all pending, cnt and is_load bits SHALL be 0, flush SHALL be 0, and pending_mask SHALL be 0. stall SHALL depend only on flush and issue_valid.
REQ-016 Reset asserted mid-operation SHALL discard all in-flight entries with no residual stall after release.

Configuration
REQ-017 Macro HAZARD_BYPASS_EN: when defined, a source SHALL NOT stall when its entry has cnt≤1 and is_load=0, and outputs fwd_a and fwd_b (1 bit each, out) SHALL flag that forwarding is required.
REQ-018 When HAZARD_BYPASS_EN is undefined, fwd_a and fwd_b SHALL be absent and REQ-005 SHALL apply unmodified.

Structure
REQ-019 Package hazard_pkg SHALL hold the counter width, NUM_REGS=32 and the latency-select enumeration (LAT_ALU, LAT_LOAD, LAT_MUL).
REQ-020 One sub-module, sb_entry, SHALL implement a single register's pending/cnt/is_load logic and be instantiated 31 times.

Verification
REQ-021 Mul to r5 accepted, then add reading r5 -> stall=1 for 5 cycles, then 0; pending_mask[5] returns to 0.
REQ-022 Load to r3 with mem_wait=1 for 4 cycles -> r3 pending for 3+4 cycles; a consumer is stalled for that whole period.
REQ-023 wb_valid with wb_addr=7 in the same cycle as an accepted write to r7 -> pending[7]=1 after the edge.
REQ-024 Instruction writing r0 -> pending_mask stays 0x00000000 and no stall.
REQ-025 Branch accepted -> flush=1 for exactly one cycle; a back-to-back branch is stalled for that cycle.
REQ-026 Reset pulse while r2 and r9 are pending -> pending_mask=0 and stall=0 on the first cycle after release.
